// File: rtl/uart_rx_buf_pkg.sv
// Shared definitions for the UART receive buffer.
// Default depth comes from `UART_RXBUF_DEPTH_LOG2, normally provided by def_ex3.v.
`ifndef UART_RXBUF_DEPTH_LOG2
`define UART_RXBUF_DEPTH_LOG2 4
`endif

package uart_rx_buf_pkg;

  localparam int unsigned RXB_DEPTH_LOG2_DEF = `UART_RXBUF_DEPTH_LOG2;
  localparam int unsigned RXB_DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } rxb_op_e;

  function automatic rxb_op_e rxb_decode(input logic push, input logic pop);
    rxb_op_e op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/uart_rx_buf_mem.sv
// Register file for the receive FIFO: synchronous write, asynchronous read.
// Contents are not reset; the top level only reads entries it has written.
module uart_rx_buf_mem #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 9
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_buf.sv
// Show-ahead receive FIFO between uart_rx and the CPU INPR/FGI port.
// Build option UART_RX_ERR_DROP_EN: discard errored bytes and count them on err_count.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = RXB_DEPTH_LOG2_DEF,
  parameter int unsigned DATA_WIDTH = RXB_DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_byte,
  input  logic                  rx_error,
  input  logic                  rx_rdy,
  input  logic                  inp_ack,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] inpr,
  output logic                  fgi,
  output logic                  head_err,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
`ifdef UART_RX_ERR_DROP_EN
  ,
  output logic [7:0]            err_count
`endif
);

  localparam logic [DEPTH_LOG2:0] FULL_C = {1'b1, {DEPTH_LOG2{1'b0}}};
`ifdef UART_RX_ERR_DROP_EN
  localparam int unsigned MEM_W = DATA_WIDTH;
`else
  localparam int unsigned MEM_W = DATA_WIDTH + 1;
`endif

  logic                  prev_rdy_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  push_req_s;
  logic                  push_ok_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  fgi_s;
  logic                  wr_en_s;
  logic                  ovf_set_s;
  logic [MEM_W-1:0]      wr_data_s;
  logic [MEM_W-1:0]      head_s;
  rxb_op_e               op_s;

  assign push_req_s = rx_rdy & ~prev_rdy_q;
  assign fgi_s      = (count_q != '0);
  assign full_s     = (count_q == FULL_C);
  assign pop_s      = inp_ack & fgi_s;

`ifdef UART_RX_ERR_DROP_EN
  logic [7:0] err_count_q, err_count_d;
  logic       err_drop_s;

  assign err_drop_s = push_req_s & rx_error;
  assign push_ok_s  = push_req_s & ~rx_error;
  assign wr_data_s  = rx_byte;

  // Saturating count of bytes discarded for a receive error.
  always_comb begin
    err_count_d = err_count_q;
    if (err_drop_s && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign push_ok_s = push_req_s;
  assign wr_data_s = {rx_error, rx_byte};
`endif

  assign op_s = rxb_decode(push_ok_s, pop_s);

  // Pop is already qualified by non-empty, so a full FIFO that pops can also accept a push.
  always_comb begin
    wr_en_s   = 1'b0;
    ovf_set_s = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    case (op_s)
      OP_PUSH: begin
        if (full_s) begin
          ovf_set_s = 1'b1;
        end else begin
          wr_en_s  = 1'b1;
          wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
          count_d  = count_q + (DEPTH_LOG2 + 1)'(1);
        end
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        count_d  = count_q - (DEPTH_LOG2 + 1)'(1);
      end
      OP_BOTH: begin
        wr_en_s  = 1'b1;
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Setting the overflow flag takes priority over clearing it.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_rdy_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_rdy_q <= rx_rdy;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  uart_rx_buf_mem #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (MEM_W)
  ) u_mem (
    .clk      (clk),
    .wr_en_i  (wr_en_s),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(wr_data_s),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(head_s)
  );

  assign fgi        = fgi_s;
  assign inpr       = fgi_s ? head_s[DATA_WIDTH-1:0] : '0;
`ifdef UART_RX_ERR_DROP_EN
  assign head_err   = 1'b0;
`else
  assign head_err   = fgi_s & head_s[DATA_WIDTH];
`endif
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Bench for uart_rx_buf: directed boundary scenarios plus randomized traffic
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_rx_buf;

  localparam int DEPTH = 16;

  logic       clk;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       rx_rdy;
  logic       inp_ack;
  logic       ovf_clr;
  logic [7:0] inpr;
  logic       fgi;
  logic       head_err;
  logic [4:0] fifo_count;
  logic       overflow;
`ifdef UART_RX_ERR_DROP_EN
  logic [7:0] err_count;
`endif

  uart_rx_buf dut (
    .clk       (clk),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_error  (rx_error),
    .rx_rdy    (rx_rdy),
    .inp_ack   (inp_ack),
    .ovf_clr   (ovf_clr),
    .inpr      (inpr),
    .fgi       (fgi),
    .head_err  (head_err),
    .fifo_count(fifo_count),
    .overflow  (overflow)
`ifdef UART_RX_ERR_DROP_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state
  logic [8:0] m_q [$];
  logic       m_prev_rdy;
  logic       m_ovf;
  int         m_errcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev_rdy = 1'b0;
    m_ovf      = 1'b0;
    m_errcnt   = 0;
  endtask

  // One clock of the reference: a rising rx_rdy delivers a byte, an ack on a non-empty FIFO removes one.
  task automatic model_step();
    logic push, pop, ovf_set;
    push       = rx_rdy && !m_prev_rdy;
    m_prev_rdy = rx_rdy;
    pop        = inp_ack && (m_q.size() > 0);
    ovf_set    = 1'b0;
`ifdef UART_RX_ERR_DROP_EN
    if (push && rx_error) begin
      push = 1'b0;
      if (m_errcnt < 255) m_errcnt++;
    end
`endif
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back({rx_error, rx_byte});
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [8:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 9'h000;
    check({tag, ".fgi"},   32'(fgi),        32'(m_q.size() > 0));
    check({tag, ".inpr"},  32'(inpr),       32'(h[7:0]));
`ifdef UART_RX_ERR_DROP_EN
    check({tag, ".herr"},  32'(head_err),   32'(0));
    check({tag, ".errc"},  32'(err_count),  32'(m_errcnt));
`else
    check({tag, ".herr"},  32'(head_err),   32'(h[8]));
`endif
    check({tag, ".count"}, 32'(fifo_count), 32'(m_q.size()));
    check({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic err, input string tag);
    rx_byte  = b;
    rx_error = err;
    rx_rdy   = 1'b1;
    tick(tag);
    rx_rdy   = 1'b0;
    tick(tag);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b0;
    rx_byte  = 8'h00;
    rx_error = 1'b0;
    rx_rdy   = 1'b0;
    inp_ack  = 1'b0;
    ovf_clr  = 1'b0;
    model_reset();

    #12;
    check("rst.fgi",   32'(fgi),        32'(0));
    check("rst.inpr",  32'(inpr),       32'(0));
    check("rst.count", 32'(fifo_count), 32'(0));
    check("rst.ovf",   32'(overflow),   32'(0));
    check("rst.herr",  32'(head_err),   32'(0));
    @(negedge clk);
    reset = 1'b1;

    // Single byte with rx_rdy held high for 50 cycles
    rx_byte = 8'h41;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 50; i++) tick("single");
    check("single.count", 32'(fifo_count), 32'(1));
    check("single.inpr",  32'(inpr),       32'(8'h41));
    rx_rdy  = 1'b0;
    inp_ack = 1'b1;
    tick("single_pop");
    inp_ack = 1'b0;
    check("single.empty_fgi",  32'(fgi),  32'(0));
    check("single.empty_inpr", 32'(inpr), 32'(0));

    // Fill past capacity: the 17th byte is lost
    for (int i = 0; i < 17; i++) push_byte(8'(i), 1'b0, "fill");
    check("fill.count", 32'(fifo_count), 32'(16));
    check("fill.ovf",   32'(overflow),   32'(1));
    inp_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fill.order", 32'(inpr), 32'(i));
      tick("fill_pop");
    end
    inp_ack = 1'b0;
    check("fill.drained", 32'(fifo_count), 32'(0));
    ovf_clr = 1'b1;
    tick("ovf_clr");
    ovf_clr = 1'b0;
    check("ovf_clr.ovf", 32'(overflow), 32'(0));

    // Push and pop together while full
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1'b0, "full2");
    rx_byte = 8'hAA;
    rx_rdy  = 1'b1;
    inp_ack = 1'b1;
    tick("simul");
    rx_rdy  = 1'b0;
    inp_ack = 1'b0;
    tick("simul");
    check("simul.count", 32'(fifo_count), 32'(16));
    check("simul.ovf",   32'(overflow),   32'(0));
    inp_ack = 1'b1;
    for (int i = 0; i < 15; i++) tick("simul_pop");
    check("simul.last", 32'(inpr), 32'(8'hAA));
    tick("simul_pop");
    inp_ack = 1'b0;

    // Empty edge cases
    inp_ack = 1'b1;
    tick("empty_ack");
    check("empty_ack.count", 32'(fifo_count), 32'(0));
    rx_byte = 8'h33;
    rx_rdy  = 1'b1;
    tick("empty_both");
    check("empty_both.count", 32'(fifo_count), 32'(1));
    rx_rdy = 1'b0;
    tick("empty_both");
    inp_ack = 1'b0;

    // Byte received with an error
    push_byte(8'h55, 1'b1, "errbyte");
`ifdef UART_RX_ERR_DROP_EN
    check("errbyte.count", 32'(fifo_count), 32'(0));
    check("errbyte.errc",  32'(err_count),  32'(1));
`else
    check("errbyte.herr", 32'(head_err), 32'(1));
    check("errbyte.inpr", 32'(inpr),     32'(8'h55));
    inp_ack = 1'b1;
    tick("errbyte_pop");
    inp_ack = 1'b0;
`endif

    // Asynchronous reset with 5 bytes buffered
    for (int i = 0; i < 5; i++) push_byte(8'(8'h60 + i), 1'b0, "prerst");
    check("prerst.count", 32'(fifo_count), 32'(5));
    #3;
    reset = 1'b0;
    #1;
    check("arst.fgi",   32'(fgi),        32'(0));
    check("arst.inpr",  32'(inpr),       32'(0));
    check("arst.count", 32'(fifo_count), 32'(0));
    check("arst.ovf",   32'(overflow),   32'(0));
    check("arst.herr",  32'(head_err),   32'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    push_byte(8'h77, 1'b0, "postrst");
    check("postrst.count", 32'(fifo_count), 32'(1));
    inp_ack = 1'b1;
    tick("postrst_pop");
    inp_ack = 1'b0;

    // Randomized traffic with varying consumer speed
    for (int ph = 0; ph < 6; ph++) begin
      int ack_pct;
      ack_pct = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 400; c++) begin
        rx_byte  = 8'($urandom);
        rx_error = ($urandom_range(0, 3) == 0);
        rx_rdy   = 1'($urandom_range(0, 1));
        inp_ack  = ($urandom_range(0, 99) < ack_pct);
        ovf_clr  = ($urandom_range(0, 15) == 0);
        tick("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
